// File: rtl/sliding_window_pkg.sv
// Shared geometry defaults, width helpers and state type for sliding_window_gen.
package sliding_window_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 16;
   localparam int unsigned DEF_IMG_WIDTH  = 28;
   localparam int unsigned DEF_IMG_HEIGHT = 28;
   localparam int unsigned DEF_KERNEL     = 5;
   localparam int unsigned DEF_STRIDE     = 1;

   // Counter width able to hold 0..n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned DEF_COL_W = cnt_width(DEF_IMG_WIDTH);
   localparam int unsigned DEF_ROW_W = cnt_width(DEF_IMG_HEIGHT);

   // Flat window slot of row r, column c for a k-wide window.
   function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                       input int unsigned k);
      return r * k + c;
   endfunction

   typedef enum logic {
      FILL   = 1'b0,
      ACTIVE = 1'b1
   } sw_state_e;

endpackage

// File: rtl/sliding_window_gen_line_delay.sv
// Enable-gated DEPTH-pixel delay built as a circular buffer; contents are not reset.
module line_delay
   import sliding_window_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 28
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);
   localparam int unsigned PTR_W = cnt_width(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      ptr_q;

   // Read-before-write at the same slot gives exactly DEPTH accepted pixels of delay.
   assign dout = mem[ptr_q];

   always_ff @(posedge clk) begin
      if (en) mem[ptr_q] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  ptr_q <= '0;
      else if (en) ptr_q <= (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
   end

endmodule

// File: rtl/sliding_window_gen.sv
// K x K sliding-window generator for raster pixel streams.
// Define SLIDING_WINDOW_OUTREG_EN to add one output register stage (2-cycle latency).
module sliding_window_gen
   import sliding_window_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int unsigned KERNEL     = DEF_KERNEL,
   parameter int unsigned STRIDE     = DEF_STRIDE
) (
   input  logic                                 CLK,
   input  logic                                 RST,
   input  logic [DATA_WIDTH-1:0]                data_in,
   input  logic                                 data_valid_in,
   input  logic                                 sof,
   output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  window,
   output logic                                 window_valid,
   output logic                                 frame_done
);
   localparam int unsigned COL_W = cnt_width(IMG_WIDTH);
   localparam int unsigned ROW_W = cnt_width(IMG_HEIGHT);
   localparam int unsigned PH_W  = cnt_width(STRIDE);
   localparam int unsigned WIN_W = KERNEL * KERNEL * DATA_WIDTH;

   sw_state_e             state_q, state_d, cur_state;
   logic [COL_W-1:0]      col_q, col_d, cur_col;
   logic [ROW_W-1:0]      row_q, row_d, cur_row;
   logic [PH_W-1:0]       col_ph_q, col_ph_d, cur_col_ph;
   logic [PH_W-1:0]       row_ph_q, row_ph_d, cur_row_ph;
   logic                  legal_c, last_c;
   logic                  valid_q, done_q;
   logic [DATA_WIDTH-1:0] win_q  [KERNEL][KERNEL];
   logic [DATA_WIDTH-1:0] row_in [KERNEL];
   logic [WIN_W-1:0]      win_flat;

   // Counters hold the position of the next pixel; sof forces the current one to (0,0).
   always_comb begin
      cur_col    = sof ? '0 : col_q;
      cur_row    = sof ? '0 : row_q;
      cur_col_ph = sof ? '0 : col_ph_q;
      cur_row_ph = sof ? '0 : row_ph_q;
      cur_state  = sof ? FILL : state_q;
      col_d      = col_q;
      row_d      = row_q;
      col_ph_d   = col_ph_q;
      row_ph_d   = row_ph_q;
      state_d    = state_q;
      legal_c    = 1'b0;
      last_c     = 1'b0;
      if (data_valid_in) begin
         legal_c = (cur_state == ACTIVE) && (cur_col >= COL_W'(KERNEL - 1)) &&
                   (cur_col_ph == '0) && (cur_row_ph == '0);
         last_c  = !sof && (cur_row == ROW_W'(IMG_HEIGHT - 1)) &&
                   (cur_col == COL_W'(IMG_WIDTH - 1));
         // Phases restart at 0 on reaching index K-1 and count modulo STRIDE after that.
         col_ph_d = ((cur_col < COL_W'(KERNEL - 1)) || (cur_col_ph == PH_W'(STRIDE - 1))) ?
                    '0 : cur_col_ph + PH_W'(1);
         row_d    = cur_row;
         row_ph_d = cur_row_ph;
         if (cur_col == COL_W'(IMG_WIDTH - 1)) begin
            col_d = '0;
            if (cur_row == ROW_W'(IMG_HEIGHT - 1)) begin
               row_d    = '0;
               row_ph_d = '0;
            end else begin
               row_d    = cur_row + ROW_W'(1);
               row_ph_d = ((cur_row < ROW_W'(KERNEL - 1)) ||
                           (cur_row_ph == PH_W'(STRIDE - 1))) ? '0 : cur_row_ph + PH_W'(1);
            end
         end else begin
            col_d = cur_col + COL_W'(1);
         end
         state_d = (row_d >= ROW_W'(KERNEL - 1)) ? ACTIVE : FILL;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= FILL;
         col_q    <= '0;
         row_q    <= '0;
         col_ph_q <= '0;
         row_ph_q <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         col_ph_q <= col_ph_d;
         row_ph_q <= row_ph_d;
         valid_q  <= legal_c;
         done_q   <= last_c;
      end
   end

   // Window rows shift left; the newest pixel of each row enters at column K-1.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int r = 0; r < int'(KERNEL); r++)
            for (int c = 0; c < int'(KERNEL); c++) win_q[r][c] <= '0;
      end else if (data_valid_in) begin
         for (int r = 0; r < int'(KERNEL); r++) begin
            for (int c = 0; c < int'(KERNEL) - 1; c++) win_q[r][c] <= win_q[r][c+1];
            win_q[r][KERNEL-1] <= row_in[r];
         end
      end
   end

   assign row_in[KERNEL-1] = data_in;

   for (genvar r = 0; r < KERNEL - 1; r++) begin : g_line
      line_delay #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (IMG_WIDTH)
      ) u_line_delay (
         .clk   (CLK),
         .rst_n (RST),
         .en    (data_valid_in),
         .din   (row_in[r+1]),
         .dout  (row_in[r])
      );
   end

   for (genvar r = 0; r < KERNEL; r++) begin : g_row
      for (genvar c = 0; c < KERNEL; c++) begin : g_col
         assign win_flat[idx(r, c, KERNEL)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
      end
   end

`ifdef SLIDING_WINDOW_OUTREG_EN
   logic [WIN_W-1:0] window_q;
   logic             window_valid_q, frame_done_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         window_q       <= '0;
         window_valid_q <= 1'b0;
         frame_done_q   <= 1'b0;
      end else begin
         window_q       <= win_flat;
         window_valid_q <= valid_q;
         frame_done_q   <= done_q;
      end
   end

   assign window       = window_q;
   assign window_valid = window_valid_q;
   assign frame_done   = frame_done_q;
`else
   assign window       = win_flat;
   assign window_valid = valid_q;
   assign frame_done   = done_q;
`endif

endmodule
